ssd_mux_ctrl: RTL and testbench
===============================

Name: ssd_mux_ctrl

Overview:
- Parametrised multiplexed seven-segment display controller: time-multiplexes NUM_DIGITS hex digits onto shared segment lines.
- Adds per-digit decimal points, per-digit blanking, leading-zero blanking, PWM brightness, selectable output polarity and a double-buffered load handshake, so frames never tear.
- Sits between the register/status logic and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits and anodes (1..16)
- REFRESH_DIV, 100000, clk cycles per digit slot (>= 2)
- PWM_W, 4, width of the brightness value and PWM counter
- ANODE_ACTIVE_LOW, 1, 1 = selected anode driven 0
- SEG_ACTIVE_LOW, 1, 1 = lit segment/dp driven 0

Ports:
- clk  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- data_i  input  4*NUM_DIGITS  hex digits; digit k = data_i[4k+3:4k], digit 0 rightmost
- dp_i  input  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_i  input  NUM_DIGITS  1 = digit forced dark
- lzb_en_i  input  1  leading-zero blanking enable
- bright_i  input  PWM_W  brightness; lit duty = bright_i / 2^PWM_W
- load_i  input  1  capture data_i/dp_i/blank_i/lzb_en_i into the shadow buffer
- pending_o  output  1  shadow buffer not yet applied
- frame_o  output  1  one-cycle pulse at each frame wrap
- anode_o  output  NUM_DIGITS  digit select
- seg_o  output  7  segments {a,b,c,d,e,f,g}, seg_o[6]=a
- dp_o  output  1  decimal point

Behaviour:
- Reset (async, active-high): slot counter, digit index, PWM counter, active and shadow buffers, pending_o and frame_o = 0. All anodes, segments and dp are inactive (all 1 when the matching *_ACTIVE_LOW=1).
- Slot counter counts 0..REFRESH_DIV-1, then wraps to 0. On wrap, the digit index increments.
- Digit index NUM_DIGITS-1 -> 0 is the frame wrap. frame_o = 1 in the same cycle the index becomes 0.
- Load handshake:
  - load_i = 1 captures the inputs into the shadow buffer and sets pending_o next cycle.
  - At a frame wrap with pending_o = 1: active buffer <= shadow, pending_o cleared.
  - load_i coincident with a frame wrap: the previous shadow is applied, the new shadow is captured, and pending_o stays 1 until the next wrap.
  - Back-to-back loads: last one wins.
  - bright_i is not buffered; it is sampled live.
- Leading-zero blanking (lzb_en active): digits from NUM_DIGITS-1 downward whose value is 0 are dark until the first nonzero digit. Digit 0 is never blanked by LZB. The dp of an LZB-blanked digit still lights if set.
- Digit dark if blank_i (active copy) is set. Its dp is also dark.
- PWM: PWM_W-bit counter increments every clk and free-runs. Anode is enabled only while pwm_cnt < bright_i.
  - bright_i = 0: display fully off.
  - bright_i = 2^PWM_W-1: duty (2^PWM_W-1)/2^PWM_W.
- Outputs are registered, one cycle after the digit index / PWM counter change. Exactly one anode is active or none; never two.
- Font: 0-9, A, b, C, d, E, F (active-high g=bit0):
  - 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47
  - Polarity is applied after lookup.
- Dark digit: anode inactive, segments inactive.
- Counter widths are $clog2 of their ranges. No truncation warnings are permitted.

Decomposition:
- Shared package ssd_pkg: the seg_t 7-bit typedef, segment bit-index constants, the 16-entry hex font constant array, and the blank pattern constant.
- One combinational sub-module ssd_hex_font (4-bit in, active-high seg_t out), reused by future display blocks.

Test Plan (bench: NUM_DIGITS=4, REFRESH_DIV=4, PWM_W=2, active-low both, bright_i=3 unless stated):
- Reset mid-frame: assert rst_i asynchronously between edges. anode_o=4'hF, seg_o=7'h7F, dp_o=1, pending_o=0 immediately. After release, digit 0 is selected first.
- Load 16'h12AF, dp_i=4'b0100, then wait for frame wrap:
  - pending_o goes 1 then 0 at the frame_o pulse.
  - Successive slots show anode 1110/1101/1011/0111 with seg F=0111000, A=0001000, 2=0010010, 1=1001111.
  - dp_o=0 only on digit 2.
- LZB: load 16'h0030 with lzb_en_i=1. Digits 3 and 2 are dark, digit 1 shows "3", digit 0 shows "0". Load 16'h0000: only digit 0 lit.
- Load at wrap: pulse load_i(16'h1111) one frame early, then load_i(16'h2222) on the frame_o cycle. The next frame shows 1111, pending_o stays 1, and the following frame shows 2222.
- PWM: bright_i=0 gives anode_o=4'hF always. bright_i=1 gives the active anode low for exactly 1 of every 4 cycles.
- Blank: blank_i=4'b0010 with dp_i=4'b0010. Digit 1's anode is never active; other digits are unaffected.

Source files
------------

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_pkg
//  Description : Shared seven-segment display types and constants.
//                seg_t bit order is {a,b,c,d,e,f,g}, so bit 6 = a and bit 0 = g.
//                Segment patterns here are active-high (1 = segment lit).
//  Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    typedef logic [6:0] seg_t;

    // Bit positions of each segment inside seg_t.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // All segments dark (active-high sense).
    localparam seg_t SEG_BLANK = 7'h00;

    // Hex font 0-9, A, b, C, d, E, F (active-high).
    localparam seg_t HEX_FONT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage
`default_nettype wire

// File: rtl/ssd_hex_font.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_hex_font
//  Description : Combinational hex-to-seven-segment decoder, active-high out.
//  Ports       : i_hex  [3:0] - hex digit value
//                o_seg  seg_t - segments {a,b,c,d,e,f,g}, 1 = lit
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd_hex_font
    import ssd_pkg::*;
(
    input  logic [3:0] i_hex,
    output seg_t       o_seg
);

    always_comb begin
        o_seg = HEX_FONT[i_hex];
    end

endmodule
`default_nettype wire

// File: rtl/ssd_mux_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_mux_ctrl
//  Description : Time-multiplexed seven-segment controller with per-digit dp,
//                blanking, leading-zero blanking, PWM brightness, selectable
//                output polarity and a double-buffered (tear-free) load.
//  Ports       : clk, rst_i (async, active-high)
//                data_i/dp_i/blank_i/lzb_en_i - frame content, captured on load_i
//                bright_i  - live brightness, duty = bright_i / 2^PWM_W
//                pending_o - shadow buffer waiting for the next frame wrap
//                frame_o   - one-cycle pulse when the digit index wraps to 0
//                anode_o/seg_o/dp_o - registered display pin drives
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd_mux_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 100000,
    parameter int PWM_W            = 4,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lzb_en_i,
    input  logic [PWM_W-1:0]        bright_i,
    input  logic                    load_i,
    output logic                    pending_o,
    output logic                    frame_o,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output seg_t                    seg_o,
    output logic                    dp_o
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0]     c_slot_last = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0]      c_dig_last  = DIG_W'(NUM_DIGITS - 1);
    // XOR masks that turn active-high drives into pin polarity; also the idle value.
    localparam logic [NUM_DIGITS-1:0] c_anode_inv = {NUM_DIGITS{(ANODE_ACTIVE_LOW != 0)}};
    localparam seg_t                  c_seg_inv   = {7{(SEG_ACTIVE_LOW != 0)}};
    localparam logic                  c_dp_inv    = (SEG_ACTIVE_LOW != 0);

    // Counters
    logic [SLOT_W-1:0] r_slot;
    logic [DIG_W-1:0]  r_digit;
    logic [PWM_W-1:0]  r_pwm;

    // Shadow (load side) and active (display side) buffers
    logic [4*NUM_DIGITS-1:0] r_sh_data,  r_act_data;
    logic [NUM_DIGITS-1:0]   r_sh_dp,    r_act_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank, r_act_blank;
    logic                    r_sh_lzb,   r_act_lzb;
    logic                    r_pending;
    logic                    r_frame;

    // Output registers
    logic [NUM_DIGITS-1:0] r_anode;
    seg_t                  r_seg;
    logic                  r_dp;

    logic                  w_slot_wrap;
    logic                  w_frame_wrap;
    logic [NUM_DIGITS-1:0] w_sel;
    logic [NUM_DIGITS-1:0] w_lzb;
    logic                  w_zero_above;
    logic [3:0]            w_nibble;
    seg_t                  w_font;
    logic                  w_lit;
    logic                  w_lead;
    logic                  w_dp_cur;
    logic                  w_show;
    logic [NUM_DIGITS-1:0] w_anode_hi;
    seg_t                  w_seg_hi;
    logic                  w_dp_hi;

    assign w_slot_wrap  = (r_slot == c_slot_last);
    assign w_frame_wrap = w_slot_wrap && (r_digit == c_dig_last);

    // ------------------------------------------------------------------
    // Slot / digit / PWM counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_slot  <= '0;
            r_digit <= '0;
            r_pwm   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_pwm   <= r_pwm + 1'b1;
            r_frame <= w_frame_wrap;
            if (w_slot_wrap) begin
                r_slot  <= '0;
                r_digit <= (r_digit == c_dig_last) ? '0 : r_digit + 1'b1;
            end else begin
                r_slot  <= r_slot + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: the shadow copy only reaches the display at a frame
    // wrap. A load on the wrap edge itself goes into the shadow while the
    // older shadow is applied, so pending stays set for one more frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_sh_data   <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_sh_lzb    <= 1'b0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
            r_act_lzb   <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            if (w_frame_wrap && r_pending) begin
                r_act_data  <= r_sh_data;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
                r_act_lzb   <= r_sh_lzb;
            end
            if (load_i) begin
                r_sh_data  <= data_i;
                r_sh_dp    <= dp_i;
                r_sh_blank <= blank_i;
                r_sh_lzb   <= lzb_en_i;
                r_pending  <= 1'b1;
            end else if (w_frame_wrap) begin
                r_pending  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero map: digit k (k >= 1) is a leading zero when it and all
    // digits above it are zero. Digit 0 is never suppressed.
    // ------------------------------------------------------------------
    always_comb begin
        w_zero_above = 1'b1;
        w_lzb        = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above && (r_act_data[4*k +: 4] == 4'h0);
            w_lzb[k]     = r_act_lzb && w_zero_above;
        end
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_sel[k] = (r_digit == DIG_W'(k));
        end
    end

    assign w_nibble = r_act_data[{r_digit, 2'b00} +: 4];

    ssd_hex_font u_font (
        .i_hex (w_nibble),
        .o_seg (w_font)
    );

    // A leading-zero digit keeps its anode only to show a set dp; its
    // segments stay dark. A blanked digit or a PWM-off phase is fully dark.
    assign w_lit      = (r_pwm < bright_i);
    assign w_lead     = w_lzb[r_digit];
    assign w_dp_cur   = r_act_dp[r_digit];
    assign w_show     = w_lit && !r_act_blank[r_digit] && (!w_lead || w_dp_cur);
    assign w_anode_hi = w_show ? w_sel : '0;
    assign w_seg_hi   = (w_show && !w_lead) ? w_font : SEG_BLANK;
    assign w_dp_hi    = w_show && w_dp_cur;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_anode <= c_anode_inv;
            r_seg   <= c_seg_inv;
            r_dp    <= c_dp_inv;
        end else begin
            r_anode <= w_anode_hi ^ c_anode_inv;
            r_seg   <= w_seg_hi ^ c_seg_inv;
            r_dp    <= w_dp_hi ^ c_dp_inv;
        end
    end

    assign anode_o   = r_anode;
    assign seg_o     = r_seg;
    assign dp_o      = r_dp;
    assign pending_o = r_pending;
    assign frame_o   = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_ssd_mux_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssd_mux_ctrl
//  Description : Self-checking bench for ssd_mux_ctrl (4 digits, 4 clk/slot,
//                2-bit PWM, active-low pins). A cycle-count based model gives
//                the expected pins every cycle; directed literals pin it down.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_mux_ctrl;

    localparam int N = 4;
    localparam int R = 4;
    localparam int P = 2;
    localparam int FRAME = N * R;

    logic        clk;
    logic        rst_i;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic [3:0]  blank_i;
    logic        lzb_en_i;
    logic [1:0]  bright_i;
    logic        load_i;
    logic        pending_o;
    logic        frame_o;
    logic [3:0]  anode_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    ssd_mux_ctrl #(
        .NUM_DIGITS       (N),
        .REFRESH_DIV      (R),
        .PWM_W            (P),
        .ANODE_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW   (1)
    ) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .dp_i      (dp_i),
        .blank_i   (blank_i),
        .lzb_en_i  (lzb_en_i),
        .bright_i  (bright_i),
        .load_i    (load_i),
        .pending_o (pending_o),
        .frame_o   (frame_o),
        .anode_o   (anode_o),
        .seg_o     (seg_o),
        .dp_o      (dp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: digit = (cycles / R) mod N, pwm = cycles mod 2^P,
    // buffers swap on frame boundaries; pins are one cycle late.
    // ------------------------------------------------------------------
    logic [6:0] font [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Returns {anode[3:0], seg[6:0], dp} at pin polarity (active-low).
    function automatic logic [11:0] model_out(input int d, input int pw,
                                              input logic [15:0] data, input logic [3:0] dp,
                                              input logic [3:0] bl, input logic lz,
                                              input logic [1:0] br);
        logic [3:0] an_hi;
        logic [6:0] sg_hi;
        logic       dp_hi;
        logic       leading;
        an_hi   = 4'b0;
        sg_hi   = 7'b0;
        dp_hi   = 1'b0;
        leading = lz && (d != 0) && ((data >> (4 * d)) == 16'h0);
        if (pw < int'(br) && !bl[d]) begin
            if (leading) begin
                if (dp[d]) begin
                    an_hi = 4'(1 << d);
                    dp_hi = 1'b1;
                end
            end else begin
                an_hi = 4'(1 << d);
                sg_hi = font[data[4*d +: 4]];
                dp_hi = dp[d];
            end
        end
        return {~an_hi, ~sg_hi, ~dp_hi};
    endfunction

    int unsigned m_cyc;
    logic [15:0] m_act_d, m_sh_d;
    logic [3:0]  m_act_dp, m_sh_dp, m_act_bl, m_sh_bl;
    logic        m_act_lz, m_sh_lz, m_pend;
    logic [11:0] e_out;
    logic        e_frame;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_cyc    <= 0;
            m_act_d  <= '0; m_sh_d  <= '0;
            m_act_dp <= '0; m_sh_dp <= '0;
            m_act_bl <= '0; m_sh_bl <= '0;
            m_act_lz <= 1'b0; m_sh_lz <= 1'b0;
            m_pend   <= 1'b0;
            e_out    <= 12'hFFF;
            e_frame  <= 1'b0;
        end else begin
            e_out   <= model_out(int'((m_cyc / R) % N), int'(m_cyc % (1 << P)),
                                 m_act_d, m_act_dp, m_act_bl, m_act_lz, bright_i);
            e_frame <= ((m_cyc + 1) % FRAME) == 0;
            if ((((m_cyc + 1) % FRAME) == 0) && m_pend) begin
                m_act_d  <= m_sh_d;
                m_act_dp <= m_sh_dp;
                m_act_bl <= m_sh_bl;
                m_act_lz <= m_sh_lz;
            end
            if (load_i) begin
                m_sh_d  <= data_i;
                m_sh_dp <= dp_i;
                m_sh_bl <= blank_i;
                m_sh_lz <= lzb_en_i;
                m_pend  <= 1'b1;
            end else if (((m_cyc + 1) % FRAME) == 0) begin
                m_pend  <= 1'b0;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_anode",   32'(anode_o),   32'(e_out[11:5] >> 3));
        chk("model_seg",     32'(seg_o),     32'(e_out[7:1]));
        chk("model_dp",      32'(dp_o),      32'(e_out[0]));
        chk("model_pending", 32'(pending_o), 32'(m_pend));
        chk("model_frame",   32'(frame_o),   32'(e_frame));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at a falling edge)
    // ------------------------------------------------------------------
    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl, input logic lz);
        data_i   = d;
        dp_i     = dp;
        blank_i  = bl;
        lzb_en_i = lz;
        load_i   = 1'b1;
        @(negedge clk);
        load_i   = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_o === 1'b1) seen = 1'b1;
        end
        chk("frame_timeout", 32'(seen), 32'd1);
    endtask

    // Called in the frame_o cycle; samples the first cycle of each slot.
    task automatic check_slots(input string tag, input logic [15:0] an_exp,
                               input logic [27:0] seg_exp, input logic [3:0] dp_exp);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk({tag, "_anode"}, 32'(anode_o), 32'(an_exp[4*k +: 4]));
            chk({tag, "_seg"},   32'(seg_o),   32'(seg_exp[7*k +: 7]));
            chk({tag, "_dp"},    32'(dp_o),    32'(dp_exp[k]));
            if (k < N - 1) repeat (R) @(negedge clk);
        end
    endtask

    task automatic count_lit(input int cycles, output int lit, output int d1_on);
        lit   = 0;
        d1_on = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (anode_o != 4'hF) lit++;
            if (anode_o[1] == 1'b0) d1_on++;
        end
    endtask

    int lit_cnt;
    int d1_cnt;

    initial begin
        rst_i    = 1'b1;
        data_i   = '0;
        dp_i     = '0;
        blank_i  = '0;
        lzb_en_i = 1'b0;
        bright_i = 2'd3;
        load_i   = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;

        // Reset mid-frame with a pending load
        repeat (6) @(negedge clk);
        do_load(16'h5678, 4'b0000, 4'b0000, 1'b0);
        repeat (5) @(negedge clk);
        chk("pre_reset_pending", 32'(pending_o), 32'd1);
        @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_anode",   32'(anode_o),   32'h0000000F);
        chk("rst_seg",     32'(seg_o),     32'h0000007F);
        chk("rst_dp",      32'(dp_o),      32'd1);
        chk("rst_pending", 32'(pending_o), 32'd0);
        chk("rst_frame",   32'(frame_o),   32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("first_digit0", 32'(anode_o), 32'h0000000E);
        chk("first_seg0",   32'(seg_o),   32'h00000001);

        // Load 12AF, dp on digit 2
        wait_frame();
        do_load(16'h12AF, 4'b0100, 4'b0000, 1'b0);
        chk("load_pending_set", 32'(pending_o), 32'd1);
        wait_frame();
        chk("wrap_pending_clr", 32'(pending_o), 32'd0);
        check_slots("hex12AF", 16'h7BDE,
                    {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1011);

        // Leading-zero blanking
        wait_frame();
        do_load(16'h0030, 4'b0000, 4'b0000, 1'b1);
        wait_frame();
        check_slots("lzb0030", 16'hFFDE,
                    {7'h7F, 7'h7F, 7'b0000110, 7'b0000001}, 4'b1111);
        wait_frame();
        do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
        wait_frame();
        check_slots("lzb0000", 16'hFFFE,
                    {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b1111);
        wait_frame();
        do_load(16'h0000, 4'b0100, 4'b0000, 1'b1);
        wait_frame();
        check_slots("lzb_dp", 16'hFBFE,
                    {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b1011);

        // Load coincident with a frame wrap
        wait_frame();
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        repeat (FRAME - 2) @(negedge clk);
        do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        chk("coinc_frame",   32'(frame_o),   32'd1);
        chk("coinc_pending", 32'(pending_o), 32'd1);
        check_slots("frame1111", 16'h7BDE,
                    {7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111}, 4'b1111);
        wait_frame();
        chk("coinc_pending_clr", 32'(pending_o), 32'd0);
        check_slots("frame2222", 16'h7BDE,
                    {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}, 4'b1111);

        // PWM brightness
        bright_i = 2'd0;
        @(negedge clk);
        count_lit(FRAME, lit_cnt, d1_cnt);
        chk("pwm0_lit", 32'(lit_cnt), 32'd0);
        bright_i = 2'd1;
        @(negedge clk);
        count_lit(FRAME, lit_cnt, d1_cnt);
        chk("pwm1_lit", 32'(lit_cnt), 32'd4);
        bright_i = 2'd3;
        @(negedge clk);

        // Blanking digit 1 (dp also set there)
        wait_frame();
        do_load(16'h1234, 4'b0010, 4'b0010, 1'b0);
        wait_frame();
        @(negedge clk);
        count_lit(FRAME, lit_cnt, d1_cnt);
        chk("blank_d1_on", 32'(d1_cnt),  32'd0);
        chk("blank_lit",   32'(lit_cnt), 32'd9);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
